// File: rtl/pipe_muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation codes and controller state encodings.
package pipe_muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_t;

endpackage

// File: rtl/pipe_muldiv_step.sv
// One iteration of the shared shift datapath: shift-add for multiply,
// restoring trial-subtract for divide.
module pipe_muldiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] opnd,
   input  logic [WIDTH-1:0] shreg,
   input  logic             is_div,
   output logic [WIDTH-1:0] acc_nx,
   output logic [WIDTH-1:0] shreg_nx
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   always_comb begin
      sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
      trial = {acc, shreg[WIDTH-1]};
      diff  = trial - {1'b0, opnd};
      if (is_div) begin
         // acc stays below the divisor, so the top bit of diff is a clean borrow
         if (!diff[WIDTH]) begin
            acc_nx   = diff[WIDTH-1:0];
            shreg_nx = {shreg[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx   = trial[WIDTH-1:0];
            shreg_nx = {shreg[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nx   = sum[WIDTH:1];
         shreg_nx = {sum[0], shreg[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// Multiply/divide sequencer beside EXE: owns HI/LO, runs one bit per cycle,
// and stalls the front end while an operation is in flight.
module pipe_muldiv_ctrl
   import pipe_muldiv_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter bit          EARLY = 1'b1
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             estart,
   input  logic [1:0]       eop,
   input  logic [WIDTH-1:0] ea,
   input  logic [WIDTH-1:0] eb,
   input  logic             emthi,
   input  logic             emtlo,
   input  logic             dhilo,
   input  logic             cancel,
   output logic             mdstall,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state, state_nx;
   op_t    op;

   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   acc, opnd, shreg;
   logic [WIDTH-1:0]   acc_nx, shreg_nx;
   logic               is_div, neg_q, neg_r, zflag, divz;

   logic               start, sgn_op, in_div, a_neg, b_neg, divz_in, zero_in;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   hi_nx, lo_nx;

   assign op      = op_t'(eop);
   assign start   = (state == S_IDLE) && estart && !cancel;
   assign sgn_op  = (op == OP_MULT) || (op == OP_DIV);
   assign in_div  = (op == OP_DIV) || (op == OP_DIVU);
   assign a_neg   = sgn_op && ea[WIDTH-1];
   assign b_neg   = sgn_op && eb[WIDTH-1];
   assign a_abs   = a_neg ? -ea : ea;
   assign b_abs   = b_neg ? -eb : eb;
   assign divz_in = in_div && (eb == '0);
   assign zero_in = EARLY && !in_div && ((ea == '0) || (eb == '0));

   assign busy    = (state != S_IDLE);
   assign mdstall = busy && dhilo;

   pipe_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .opnd     (opnd),
      .shreg    (shreg),
      .is_div   (is_div),
      .acc_nx   (acc_nx),
      .shreg_nx (shreg_nx)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (start) state_nx = divz_in ? S_FIX : S_RUN;
         S_RUN:  if (zflag || (cnt == LAST)) state_nx = S_FIX;
         S_FIX:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (cancel) state_nx = S_IDLE;
   end

   // On divide-by-zero shreg carries the raw dividend so FIX can return it in HI
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         shreg  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         zflag  <= 1'b0;
         divz   <= 1'b0;
      end else if (start) begin
         cnt    <= '0;
         acc    <= '0;
         opnd   <= b_abs;
         shreg  <= divz_in ? ea : a_abs;
         is_div <= in_div;
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         zflag  <= zero_in;
         divz   <= divz_in;
      end else if ((state == S_RUN) && !cancel) begin
         cnt    <= cnt + CW'(1);
         acc    <= acc_nx;
         shreg  <= shreg_nx;
      end
   end

   always_comb begin
      prod     = {acc, shreg};
      prod_fix = neg_q ? -prod : prod;
      if (zflag) prod_fix = '0;
      if (!is_div) begin
         hi_nx = prod_fix[2*WIDTH-1:WIDTH];
         lo_nx = prod_fix[WIDTH-1:0];
      end else if (divz) begin
         hi_nx = shreg;
         lo_nx = '1;
      end else begin
         hi_nx = neg_r ? -acc : acc;
         lo_nx = neg_q ? -shreg : shreg;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hi <= '0;
         lo <= '0;
      end else if ((state == S_FIX) && !cancel) begin
         hi <= hi_nx;
         lo <= lo_nx;
      end else if ((state == S_IDLE) && !estart) begin
         if (emthi) hi <= ea;
         if (emtlo) lo <= ea;
      end
   end

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Directed self-checking bench for pipe_muldiv_ctrl (WIDTH=32, EARLY=1).
module tb_pipe_muldiv_ctrl;

   logic        clock = 1'b0;
   logic        resetn;
   logic        estart, emthi, emtlo, dhilo, cancel;
   logic [1:0]  eop;
   logic [31:0] ea, eb;
   logic        mdstall, busy;
   logic [31:0] hi, lo;

   int tests = 0;
   int fails = 0;

   pipe_muldiv_ctrl #(.WIDTH(32), .EARLY(1'b1)) dut (
      .clock   (clock),
      .resetn  (resetn),
      .estart  (estart),
      .eop     (eop),
      .ea      (ea),
      .eb      (eb),
      .emthi   (emthi),
      .emtlo   (emtlo),
      .dhilo   (dhilo),
      .cancel  (cancel),
      .mdstall (mdstall),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
      estart = 1'b1; eop = op; ea = a; eb = b;
      tick();
      estart = 1'b0; ea = '0; eb = '0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      logic stall_ok;

      resetn = 1'b0; estart = 1'b0; eop = 2'b00; ea = '0; eb = '0;
      emthi = 1'b0; emtlo = 1'b0; dhilo = 1'b0; cancel = 1'b0;
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mdstall", 64'(mdstall), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      resetn = 1'b1;
      tick();

      do_op(2'b00, 32'hFFFF_FFFD, 32'd7, n);
      check("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);
      check("mult_busy_cycles", 64'(n), 64'd33);

      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      check("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      check("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, n);
      check("div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      check("div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check("div_busy_cycles", 64'(n), 64'd33);

      do_op(2'b11, 32'd100, 32'd7, n);
      check("divu_lo", 64'(lo), 64'd14);
      check("divu_hi", 64'(hi), 64'd2);

      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
      check("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
      check("div_ovf_hi", 64'(hi), 64'd0);

      do_op(2'b11, 32'd5, 32'd0, n);
      check("divz_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
      check("divz_hi", 64'(hi), 64'd5);
      check("divz_busy_cycles", 64'(n), 64'd1);

      do_op(2'b01, 32'd7, 32'd3, n);
      check("multu_small_lo", 64'(lo), 64'd21);
      do_op(2'b00, 32'd0, 32'd1234, n);
      check("early_hi", 64'(hi), 64'd0);
      check("early_lo", 64'(lo), 64'd0);
      check("early_busy_cycles", 64'(n), 64'd2);

      emthi = 1'b1; ea = 32'h1234_5678;
      tick();
      emthi = 1'b0; emtlo = 1'b1; ea = 32'h9ABC_DEF0;
      tick();
      emtlo = 1'b0; ea = '0;
      check("mthi_idle", 64'(hi), 64'h0000_0000_1234_5678);
      check("mtlo_idle", 64'(lo), 64'h0000_0000_9ABC_DEF0);

      estart = 1'b1; eop = 2'b11; ea = 32'd100; eb = 32'd7; dhilo = 1'b1;
      tick();
      estart = 1'b0; ea = '0; eb = '0;
      n = 0; stall_ok = 1'b1;
      while (busy && n < 100) begin
         if (mdstall !== 1'b1) stall_ok = 1'b0;
         if (n == 5) begin
            emthi = 1'b1; ea = 32'hDEAD_BEEF; estart = 1'b1; eop = 2'b01; eb = 32'd3;
         end
         if (n == 6) begin
            emthi = 1'b0; estart = 1'b0; ea = '0; eb = '0;
            check("mthi_ignored_busy", 64'(hi), 64'h0000_0000_1234_5678);
         end
         n++;
         tick();
      end
      check("mdstall_all_busy", 64'(stall_ok), 64'd1);
      check("stall_busy_cycles", 64'(n), 64'd33);
      check("stall_divu_lo", 64'(lo), 64'd14);
      check("stall_divu_hi", 64'(hi), 64'd2);
      check("mdstall_idle", 64'(mdstall), 64'd0);
      dhilo = 1'b0;

      estart = 1'b1; eop = 2'b01; ea = 32'd3; eb = 32'd5;
      tick();
      estart = 1'b0; ea = '0; eb = '0;
      repeat (9) tick();
      check("cancel_pre_busy", 64'(busy), 64'd1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("cancel_busy", 64'(busy), 64'd0);
      repeat (40) tick();
      check("cancel_hi", 64'(hi), 64'd2);
      check("cancel_lo", 64'(lo), 64'd14);

      estart = 1'b1; cancel = 1'b1; eop = 2'b01; ea = 32'd3; eb = 32'd5;
      tick();
      estart = 1'b0; cancel = 1'b0; ea = '0; eb = '0;
      check("cancel_beats_start", 64'(busy), 64'd0);

      estart = 1'b1; emthi = 1'b1; emtlo = 1'b1; eop = 2'b01; ea = 32'h10; eb = 32'd3;
      tick();
      estart = 1'b0; emthi = 1'b0; emtlo = 1'b0; ea = '0; eb = '0;
      check("start_beats_mthi", 64'(hi), 64'd2);
      check("start_beats_mtlo", 64'(lo), 64'd14);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      check("start_mt_lo", 64'(lo), 64'h30);
      check("start_mt_hi", 64'(hi), 64'd0);

      estart = 1'b1; eop = 2'b00; ea = 32'd7; eb = 32'd9;
      tick();
      estart = 1'b0; ea = '0; eb = '0;
      repeat (5) tick();
      resetn = 1'b0;
      #2;
      check("midrun_rst_busy", 64'(busy), 64'd0);
      check("midrun_rst_hi", 64'(hi), 64'd0);
      check("midrun_rst_lo", 64'(lo), 64'd0);
      tick();
      resetn = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
